// File: rtl/vx_cam_table_if.sv
// Request/response channel bundle for vx_cam_table.
// The master issues requests and consumes responses; the slave is the table.
interface vx_cam_table_if #(
    parameter int KEYW  = 32,
    parameter int DATAW = 32,
    parameter int IDXW  = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [KEYW-1:0]  req_key;
    logic [DATAW-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic             rsp_err;
    logic [IDXW-1:0]  rsp_index;
    logic [DATAW-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_key, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_err, rsp_index, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_key, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_err, rsp_index, rsp_data
    );
endinterface

// File: rtl/vx_cam_table.sv
// vx_cam_table: small key/data associative table with valid/ready request and response channels.
// A single response register; the table update and the response capture share the acceptance edge.
module vx_cam_table #(
    parameter int N     = 8,
    parameter int KEYW  = 32,
    parameter int DATAW = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    vx_cam_table_if.slave       bus,
    output logic [$clog2(N):0]  count,
    output logic                full,
    output logic                empty
);
    localparam int IDXW = $clog2(N);

    localparam logic [2:0] OP_LOOKUP   = 3'b000;
    localparam logic [2:0] OP_INSERT   = 3'b001;
    localparam logic [2:0] OP_UPDATE   = 3'b010;
    localparam logic [2:0] OP_REMOVE   = 3'b011;
    localparam logic [2:0] OP_READ     = 3'b100;
    localparam logic [2:0] OP_READ_IDX = 3'b101;

    logic [N-1:0]     valid_r;
    logic [KEYW-1:0]  key_r  [N];
    logic [DATAW-1:0] data_r [N];

    logic             rsp_valid_r;
    logic             rsp_hit_r;
    logic             rsp_err_r;
    logic [IDXW-1:0]  rsp_index_r;
    logic [DATAW-1:0] rsp_data_r;
    logic [IDXW:0]    count_r;
    logic             full_r;
    logic             empty_r;

    logic             accept_s;
    logic             match_hit_s;
    logic [IDXW-1:0]  match_idx_s;
    logic [DATAW-1:0] match_data_s;
    logic             free_hit_s;
    logic [IDXW-1:0]  free_idx_s;
    logic [IDXW-1:0]  ridx_s;
    logic             ridx_ok_s;
    logic             ridx_valid_s;
    logic [DATAW-1:0] ridx_data_s;

    logic [N-1:0]     valid_nxt_s;
    logic             wr_en_s;
    logic [IDXW-1:0]  wr_idx_s;
    logic             hit_nxt_s;
    logic             err_nxt_s;
    logic [IDXW-1:0]  index_nxt_s;
    logic [DATAW-1:0] data_nxt_s;
    logic [IDXW:0]    count_nxt_s;

    assign accept_s      = bus.req_valid & bus.req_ready;
    assign bus.req_ready = ~flush & (~rsp_valid_r | bus.rsp_ready);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_hit   = rsp_hit_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_index = rsp_index_r;
    assign bus.rsp_data  = rsp_data_r;
    assign count         = count_r;
    assign full          = full_r;
    assign empty         = empty_r;

    // Key match, lowest free slot and direct-index read, all from pre-update state
    always_comb begin
        match_hit_s = 1'b0;
        match_idx_s = {IDXW{1'b0}};
        free_hit_s  = 1'b0;
        free_idx_s  = {IDXW{1'b0}};
        // Scanning downwards lets the lowest index overwrite any higher candidate
        for (int i = N - 1; i >= 0; i--) begin
            match_hit_s = (valid_r[i] && (key_r[i] == bus.req_key)) ? 1'b1 : match_hit_s;
            match_idx_s = (valid_r[i] && (key_r[i] == bus.req_key)) ? IDXW'(i) : match_idx_s;
            free_hit_s  = (!valid_r[i]) ? 1'b1 : free_hit_s;
            free_idx_s  = (!valid_r[i]) ? IDXW'(i) : free_idx_s;
        end
        match_data_s = data_r[match_idx_s];
        ridx_s       = bus.req_key[IDXW-1:0];
        ridx_ok_s    = ({1'b0, ridx_s} < (IDXW+1)'(N));
        ridx_valid_s = ridx_ok_s ? valid_r[ridx_s] : 1'b0;
        ridx_data_s  = ridx_ok_s ? data_r[ridx_s] : {DATAW{1'b0}};
    end

    // Operation decode: next valid vector, write strobe and response fields
    always_comb begin
        valid_nxt_s = valid_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = match_idx_s;
        hit_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        index_nxt_s = {IDXW{1'b0}};
        data_nxt_s  = {DATAW{1'b0}};
        case (bus.req_op)
            OP_LOOKUP, OP_READ: begin
                if (match_hit_s) begin
                    hit_nxt_s   = 1'b1;
                    index_nxt_s = match_idx_s;
                    data_nxt_s  = match_data_s;
                end else begin
                    hit_nxt_s   = 1'b0;
                end
            end
            OP_INSERT: begin
                if (match_hit_s) begin
                    wr_en_s     = 1'b1;
                    hit_nxt_s   = 1'b1;
                    index_nxt_s = match_idx_s;
                end else if (free_hit_s) begin
                    wr_en_s                 = 1'b1;
                    wr_idx_s                = free_idx_s;
                    valid_nxt_s[free_idx_s] = 1'b1;
                    index_nxt_s             = free_idx_s;
                end else begin
                    err_nxt_s   = 1'b1;
                end
            end
            OP_UPDATE: begin
                if (match_hit_s) begin
                    wr_en_s     = 1'b1;
                    hit_nxt_s   = 1'b1;
                    index_nxt_s = match_idx_s;
                    data_nxt_s  = match_data_s;
                end else begin
                    err_nxt_s   = 1'b1;
                end
            end
            OP_REMOVE: begin
                if (match_hit_s) begin
                    valid_nxt_s[match_idx_s] = 1'b0;
                    hit_nxt_s                = 1'b1;
                    index_nxt_s              = match_idx_s;
                    data_nxt_s               = match_data_s;
                end else begin
                    err_nxt_s   = 1'b1;
                end
            end
            OP_READ_IDX: begin
                if (ridx_ok_s) begin
                    hit_nxt_s   = ridx_valid_s;
                    index_nxt_s = ridx_s;
                    data_nxt_s  = ridx_data_s;
                end else begin
                    err_nxt_s   = 1'b1;
                end
            end
            default: begin
                err_nxt_s = 1'b1;
            end
        endcase
        count_nxt_s = {(IDXW+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            count_nxt_s = count_nxt_s + (IDXW+1)'(valid_nxt_s[i]);
        end
    end

    // Valid bits, occupancy flags and the response register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_r     <= {N{1'b0}};
            count_r     <= {(IDXW+1){1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_index_r <= {IDXW{1'b0}};
            rsp_data_r  <= {DATAW{1'b0}};
        end else begin
            if (flush) begin
                valid_r <= {N{1'b0}};
                count_r <= {(IDXW+1){1'b0}};
                full_r  <= 1'b0;
                empty_r <= 1'b1;
            end else if (accept_s) begin
                valid_r <= valid_nxt_s;
                count_r <= count_nxt_s;
                full_r  <= (count_nxt_s == (IDXW+1)'(N));
                empty_r <= (count_nxt_s == {(IDXW+1){1'b0}});
            end
            if (accept_s) begin
                rsp_valid_r <= 1'b1;
                rsp_hit_r   <= hit_nxt_s;
                rsp_err_r   <= err_nxt_s;
                rsp_index_r <= index_nxt_s;
                rsp_data_r  <= data_nxt_s;
            end else if (bus.rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    // Key/data storage is not reset; valid_r alone qualifies its contents
    always_ff @(posedge clk) begin
        if (accept_s && wr_en_s) begin
            key_r[wr_idx_s]  <= bus.req_key;
            data_r[wr_idx_s] <= bus.req_data;
        end
    end
endmodule

// File: tb/tb_vx_cam_table.sv
// Randomised and directed bench for vx_cam_table with a queue scoreboard and a
// behavioural table model (N=4, KEYW=8, DATAW=8).
module tb_vx_cam_table;
    localparam int N     = 4;
    localparam int KEYW  = 8;
    localparam int DATAW = 8;
    localparam int IDXW  = 2;

    localparam logic [2:0] LOOKUP = 3'd0, INSERT = 3'd1, UPDATE = 3'd2,
                           REMOVE = 3'd3, READ = 3'd4, READ_IDX = 3'd5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic [IDXW:0] count;
    logic          full;
    logic          empty;

    vx_cam_table_if #(.KEYW(KEYW), .DATAW(DATAW), .IDXW(IDXW)) bus ();

    vx_cam_table #(.N(N), .KEYW(KEYW), .DATAW(DATAW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             hit;
        logic             err;
        logic [IDXW-1:0]  idx;
        logic [DATAW-1:0] data;
        bit               data_chk;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   ready_mode  = 0;

    bit               m_valid [N];
    logic [KEYW-1:0]  m_key   [N];
    logic [DATAW-1:0] m_data  [N];
    bit               m_known [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endfunction

    // Table semantics: find the lowest valid entry with this key, the lowest empty slot, then act
    function automatic exp_t model_apply(input logic [2:0] op, input logic [KEYW-1:0] key,
                                         input logic [DATAW-1:0] data);
        exp_t e;
        int   m = -1;
        int   f = -1;
        int   ix;
        e.hit = 1'b0; e.err = 1'b0; e.idx = '0; e.data = '0; e.data_chk = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m < 0 && m_valid[i] && m_key[i] == key) m = i;
            if (f < 0 && !m_valid[i]) f = i;
        end
        case (op)
            LOOKUP, READ: begin
                if (m >= 0) begin e.hit = 1'b1; e.idx = IDXW'(m); e.data = m_data[m]; end
            end
            INSERT: begin
                if (m >= 0) begin
                    e.hit = 1'b1; e.idx = IDXW'(m); m_data[m] = data;
                end else if (f >= 0) begin
                    e.idx = IDXW'(f); m_valid[f] = 1'b1; m_key[f] = key;
                    m_data[f] = data; m_known[f] = 1'b1;
                end else e.err = 1'b1;
            end
            UPDATE: begin
                if (m >= 0) begin
                    e.hit = 1'b1; e.idx = IDXW'(m); e.data = m_data[m]; m_data[m] = data;
                end else e.err = 1'b1;
            end
            REMOVE: begin
                if (m >= 0) begin
                    e.hit = 1'b1; e.idx = IDXW'(m); e.data = m_data[m]; m_valid[m] = 1'b0;
                end else e.err = 1'b1;
            end
            READ_IDX: begin
                ix = int'(key[IDXW-1:0]);
                if (ix >= N) e.err = 1'b1;
                else begin
                    e.hit = m_valid[ix]; e.idx = IDXW'(ix);
                    e.data = m_data[ix]; e.data_chk = m_known[ix];
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Drive one request until accepted, record its expected response, check latency/occupancy
    task automatic issue(input logic [2:0] op, input logic [KEYW-1:0] key, input logic [DATAW-1:0] data);
        bit acc = 1'b0;
        int guard = 0;
        exp_t e;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_key = key; bus.req_data = data;
        while (!acc && guard < 200) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = 1'b1;
                e = model_apply(op, key, data);
                q.push_back(e);
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        else begin
            chk("rsp_latency", 32'(bus.rsp_valid), 32'd1);
            chk("count", 32'(count), 32'(model_count()));
            chk("full", 32'(full), 32'(model_count() == N));
            chk("empty", 32'(empty), 32'(model_count() == 0));
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((q.size() != 0 || bus.rsp_valid) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_ready_mode(input int mode);
        ready_mode = mode;
        @(posedge clk); #2;
    endtask

    // Response consumer: 0 always ready, 1 random back-pressure, 2 stalled
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: compare on every completed response handshake
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                else begin
                    mon_e = q.pop_front();
                    chk("rsp_hit", 32'(bus.rsp_hit), 32'(mon_e.hit));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                    chk("rsp_index", 32'(bus.rsp_index), 32'(mon_e.idx));
                    if (mon_e.data_chk) chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_key = '0; bus.req_data = '0;
        flush = 1'b0; reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_known[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rsp_fields", {bus.rsp_hit, bus.rsp_err, 14'(bus.rsp_index), 16'(bus.rsp_data)}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table scenario
        issue(LOOKUP, 8'h11, 8'h00);
        issue(INSERT, 8'h11, 8'hA1);
        issue(INSERT, 8'h22, 8'hB2);
        issue(INSERT, 8'h33, 8'hC3);
        issue(INSERT, 8'h44, 8'hD4);
        chk("full_after_4", 32'(full), 32'd1);
        issue(INSERT, 8'h55, 8'h99);
        issue(INSERT, 8'h22, 8'hEE);
        issue(READ, 8'h22, 8'h00);
        issue(REMOVE, 8'h11, 8'h00);
        issue(INSERT, 8'h66, 8'h01);
        issue(UPDATE, 8'h33, 8'h5C);
        issue(UPDATE, 8'h77, 8'h00);
        issue(REMOVE, 8'h77, 8'h00);
        issue(READ, 8'h77, 8'h00);
        issue(READ_IDX, 8'h02, 8'h00);
        issue(3'd6, 8'h22, 8'h00);
        issue(3'd7, 8'h22, 8'h00);
        wait_idle();

        // Back-pressure: response held, request blocked
        set_ready_mode(2);
        issue(LOOKUP, 8'h33, 8'h00);
        bus.req_valid = 1'b1; bus.req_op = READ; bus.req_key = 8'h66; bus.req_data = 8'h00;
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            if (q.size() != 0) chk("stall_rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
            else chk("stall_queue", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        ready_mode = 0;
        issue(READ, 8'h66, 8'h00);
        wait_idle();

        // Flush with an attempted request in the same cycle
        bus.req_valid = 1'b1; bus.req_op = INSERT; bus.req_key = 8'h77; bus.req_data = 8'h07;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; bus.req_valid = 1'b0;
        model_clear();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_no_rsp", 32'(bus.rsp_valid), 32'd0);
        issue(LOOKUP, 8'h22, 8'h00);
        issue(LOOKUP, 8'h66, 8'h00);
        issue(LOOKUP, 8'h77, 8'h00);

        // Flush while a response is pending: response survives unchanged
        issue(INSERT, 8'h2A, 8'h3B);
        wait_idle();
        set_ready_mode(2);
        issue(LOOKUP, 8'h2A, 8'h00);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        chk("flush_pending_valid", 32'(bus.rsp_valid), 32'd1);
        chk("flush_pending_hit", 32'(bus.rsp_hit), 32'd1);
        chk("flush_pending_count", 32'(count), 32'd0);
        ready_mode = 0;
        wait_idle();
        issue(LOOKUP, 8'h2A, 8'h00);

        // Randomised traffic with back-pressure
        ready_mode = 1;
        repeat (400) begin
            logic [2:0] op;
            logic [7:0] key;
            op  = 3'($urandom_range(0, 7));
            key = (op == READ_IDX) ? 8'($urandom_range(0, 255)) : 8'(8'h10 + $urandom_range(0, 5));
            issue(op, key, 8'($urandom_range(0, 255)));
        end
        ready_mode = 0;
        wait_idle();

        // Reset with a pending response; stored data survives for READ_IDX
        set_ready_mode(2);
        issue(LOOKUP, 8'h12, 8'h00);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_pending_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_pending_count", 32'(count), 32'd0);
        chk("rst_pending_empty", 32'(empty), 32'd1);
        q.delete();
        model_clear();
        reset_n = 1'b1;
        ready_mode = 0;
        for (int i = 0; i < N; i++) issue(READ_IDX, 8'(i), 8'h00);
        issue(LOOKUP, 8'h12, 8'h00);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
